// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, legality check and the queued command record
package alu_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;
  localparam int ALU_TAG_MAX_W = 16;
  typedef struct packed {
    logic [31:0]              src1;
    logic [31:0]              src2;
    logic [3:0]               ctrl;
    logic [ALU_TAG_MAX_W-1:0] tag;
  } alu_cmd_t;
  function automatic logic is_legal_ctrl(input logic [3:0] c);
    return c == ALU_AND || c == ALU_OR || c == ALU_ADD || c == ALU_SUB ||
           c == ALU_SLT || c == ALU_NOR || c == ALU_NAND;
  endfunction
endpackage

// File: rtl/alu.sv
// alu: 32-bit combinational ALU; outputs forced to zero while rst_n is low
module alu
  import alu_pkg::*;
(
  input  logic        rst_n,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [3:0]  ALU_control,
  output logic [31:0] result,
  output logic        zero,
  output logic        cout,
  output logic        overflow
);
  logic [32:0] sum, diff;
  logic        add_ovf, sub_ovf;
  logic [31:0] res;
  // SUB/SLT share one subtractor; SLT is the signed sign-of-difference corrected by overflow
  always_comb begin
    sum      = {1'b0, src1} + {1'b0, src2};
    diff     = {1'b0, src1} + {1'b0, ~src2} + 33'd1;
    add_ovf  = (src1[31] == src2[31]) && (sum[31] != src1[31]);
    sub_ovf  = (src1[31] != src2[31]) && (diff[31] != src1[31]);
    res      = ALU_control == ALU_AND  ? src1 & src2 :
               ALU_control == ALU_OR   ? src1 | src2 :
               ALU_control == ALU_ADD  ? sum[31:0] :
               ALU_control == ALU_SUB  ? diff[31:0] :
               ALU_control == ALU_SLT  ? {31'd0, diff[31] ^ sub_ovf} :
               ALU_control == ALU_NOR  ? ~(src1 | src2) :
               ALU_control == ALU_NAND ? ~(src1 & src2) : 32'd0;
    result   = rst_n ? res : 32'd0;
    zero     = rst_n && res == 32'd0;
    cout     = rst_n && (ALU_control == ALU_ADD ? sum[32] : ALU_control == ALU_SUB && diff[32]);
    overflow = rst_n && (ALU_control == ALU_ADD ? add_ovf : ALU_control == ALU_SUB && sub_ovf);
  end
endmodule

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO of command records with occupancy count
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = alu_cmd_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;
  // pointer and occupancy next-state; pointers wrap naturally at DEPTH
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end
  assign dout  = mem[rd_ptr_q];
  assign full  = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: FIFO-buffered, registered ALU port; ALU_STICKY_FLAGS_EN adds sticky ovf/cout
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [3:0]       in_ctrl,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_cout,
  output logic             out_overflow,
  output logic [TAG_W-1:0] out_tag,
  output logic             err_illegal,
  input  logic             flags_clr,
  output logic             sticky_ovf,
  output logic             sticky_cout
);
  alu_cmd_t                 cmd_in, head;
  logic                     full, empty, accept, issue;
  logic [$clog2(DEPTH):0]   count_unused;
  logic [ALU_TAG_MAX_W-1:0] head_tag_unused;
  logic [31:0]              alu_result;
  logic                     alu_zero, alu_cout, alu_ovf;
  logic                     out_valid_q, out_valid_d, out_zero_q, out_zero_d;
  logic                     out_cout_q, out_cout_d, out_ovf_q, out_ovf_d;
  logic                     err_q, err_d;
  logic [31:0]              out_result_q, out_result_d;
  logic [TAG_W-1:0]         out_tag_q, out_tag_d;
  assign cmd_in          = '{src1: in_src1, src2: in_src2, ctrl: in_ctrl, tag: ALU_TAG_MAX_W'(in_tag)};
  assign accept          = in_valid && in_ready;
  assign in_ready        = !full;
  assign issue           = !empty && (!out_valid_q || out_ready);
  assign head_tag_unused = head.tag;
  alu_cmd_fifo #(.DEPTH(DEPTH), .T(alu_cmd_t)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(accept && is_legal_ctrl(in_ctrl)), .pop(issue),
    .din(cmd_in), .dout(head), .full(full), .empty(empty), .count(count_unused)
  );
  alu u_alu (
    .rst_n(rst_n), .src1(head.src1), .src2(head.src2), .ALU_control(head.ctrl),
    .result(alu_result), .zero(alu_zero), .cout(alu_cout), .overflow(alu_ovf)
  );
  // output register loads on issue, drains when consumed, holds under backpressure
  always_comb begin
    out_valid_d  = issue || (out_valid_q && !out_ready);
    out_result_d = issue ? alu_result : out_result_q;
    out_zero_d   = issue ? alu_zero : out_zero_q;
    out_cout_d   = issue ? alu_cout : out_cout_q;
    out_ovf_d    = issue ? alu_ovf : out_ovf_q;
    out_tag_d    = issue ? head.tag[TAG_W-1:0] : out_tag_q;
    err_d        = accept && !is_legal_ctrl(in_ctrl);
  end
  // output register and illegal-code pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
      out_cout_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_tag_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_zero_q   <= out_zero_d;
      out_cout_q   <= out_cout_d;
      out_ovf_q    <= out_ovf_d;
      out_tag_q    <= out_tag_d;
      err_q        <= err_d;
    end
  end
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_zero     = out_zero_q;
  assign out_cout     = out_cout_q;
  assign out_overflow = out_ovf_q;
  assign out_tag      = out_tag_q;
  assign err_illegal  = err_q;
`ifdef ALU_STICKY_FLAGS_EN
  logic sticky_ovf_q, sticky_ovf_d, sticky_cout_q, sticky_cout_d;
  // sticky flags: a set on issue wins over a coincident clear
  always_comb begin
    sticky_ovf_d  = (issue && alu_ovf) || (sticky_ovf_q && !flags_clr);
    sticky_cout_d = (issue && alu_cout) || (sticky_cout_q && !flags_clr);
  end
  // sticky flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf_q  <= 1'b0;
      sticky_cout_q <= 1'b0;
    end else begin
      sticky_ovf_q  <= sticky_ovf_d;
      sticky_cout_q <= sticky_cout_d;
    end
  end
  assign sticky_ovf  = sticky_ovf_q;
  assign sticky_cout = sticky_cout_q;
`else
  logic flags_clr_unused;
  assign flags_clr_unused = flags_clr;
  assign sticky_ovf       = 1'b0;
  assign sticky_cout      = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed self-checking bench for alu_issue_queue
module tb_alu_issue_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1, flags_clr = 1'b0;
  logic [31:0] in_src1 = '0, in_src2 = '0;
  logic [3:0]  in_ctrl = '0, in_tag = '0;
  logic        in_ready, out_valid, out_zero, out_cout, out_overflow;
  logic        err_illegal, sticky_ovf, sticky_cout;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  int          checks = 0, failures = 0;
  alu_issue_queue #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_ctrl(in_ctrl), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_cout(out_cout), .out_overflow(out_overflow),
    .out_tag(out_tag), .err_illegal(err_illegal), .flags_clr(flags_clr),
    .sticky_ovf(sticky_ovf), .sticky_cout(sticky_cout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    in_valid = 1'b1; in_ctrl = c; in_src1 = a; in_src2 = b; in_tag = t;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic chk_out(input string tag, input logic [31:0] res, input logic z, input logic c,
                         input logic o, input logic [3:0] t);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, out_result, res);
    chk({tag, "_flags"}, {29'd0, out_zero, out_cout, out_overflow}, {29'd0, z, c, o});
    chk({tag, "_tag"}, 32'(out_tag), 32'(t));
  endtask
  typedef struct { logic [3:0] c; logic [31:0] a, b, r; logic z, co, o; } vec_t;
  vec_t vecs [5] = '{
    '{4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1, 1'b0},
    '{4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0},
    '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0},
    '{4'b1100, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'd0, 1'b1, 1'b0, 1'b0},
    '{4'b1101, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FFFF, 1'b0, 1'b0, 1'b0}
  };
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out", {out_result[31:0]}, 32'd0);
    chk("rst_bits", {24'd0, out_valid, out_zero, out_cout, out_overflow, out_tag}, 32'd0);
    chk("rst_err_sticky", {29'd0, err_illegal, sticky_ovf, sticky_cout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send(4'b0010, 32'h7FFF_FFFF, 32'd1, 4'd9);
    chk("add_lat0", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk_out("add", 32'h8000_0000, 1'b0, 1'b0, 1'b1, 4'd9);
    @(negedge clk);
    chk("add_drain", 32'(out_valid), 32'd0);
    foreach (vecs[i]) begin
      send(vecs[i].c, vecs[i].a, vecs[i].b, 4'(i));
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), vecs[i].r, vecs[i].z, vecs[i].co, vecs[i].o, 4'(i));
      @(negedge clk);
    end
    out_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      in_valid = 1'b1; in_ctrl = 4'b0010; in_src1 = 32'(t); in_src2 = 32'd100; in_tag = 4'(t);
      chk($sformatf("bp_ready%0d", t), 32'(in_ready), 32'(t < 5));
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk_out("bp_hold", 32'd100, 1'b0, 1'b0, 1'b0, 4'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk_out($sformatf("bp_ret%0d", k), 32'(k + 100), 1'b0, 1'b0, 1'b0, 4'(k));
      @(negedge clk);
    end
    chk("bp_done", 32'(out_valid), 32'd0);
    send(4'b0011, 32'd1, 32'd2, 4'd7);
    chk("ill_err", 32'(err_illegal), 32'd1);
    chk("ill_noval", 32'(out_valid), 32'd0);
    send(4'b0001, 32'h0000_00F0, 32'h0000_000F, 4'd8);
    chk("ill_err_once", 32'(err_illegal), 32'd0);
    chk("ill_noval2", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk_out("or_after_ill", 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 4'd8);
    @(negedge clk);
    out_ready = 1'b0;
    send(4'b0000, 32'd1, 32'd1, 4'd1);
    send(4'b0000, 32'd2, 32'd2, 4'd2);
    send(4'b0000, 32'd3, 32'd3, 4'd3);
    chk("mid_valid_pre", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mid_stale%0d", k), 32'(out_valid), 32'd0);
    end
`ifdef ALU_STICKY_FLAGS_EN
    send(4'b0010, 32'h7FFF_FFFF, 32'd1, 4'd1);
    @(negedge clk);
    chk("st_set", {30'd0, sticky_ovf, sticky_cout}, 32'd2);
    send(4'b0000, 32'd3, 32'd5, 4'd2);
    @(negedge clk);
    chk("st_hold", {30'd0, sticky_ovf, sticky_cout}, 32'd2);
    send(4'b0010, 32'hFFFF_FFFF, 32'd1, 4'd3);
    @(negedge clk);
    chk("st_cout", {30'd0, sticky_ovf, sticky_cout}, 32'd3);
    send(4'b0010, 32'h7FFF_FFFF, 32'd1, 4'd4);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    chk("st_set_wins", {30'd0, sticky_ovf, sticky_cout}, 32'd2);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    chk("st_clr", {30'd0, sticky_ovf, sticky_cout}, 32'd0);
`else
    send(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1);
    @(negedge clk);
    chk("st_off_out", {30'd0, out_cout, out_overflow}, 32'd2);
    chk("st_off", {30'd0, sticky_ovf, sticky_cout}, 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Registered issue/retire stage wrapped around the 32-bit combinational `alu`. It buffers ALU commands in a small FIFO and drives the head command's operands into an internal `alu` instance. It captures the result and flags into an output register with valid/ready handshakes on both sides. This gives the datapath a clocked, back-pressurable ALU port.

## Interface
- `DEPTH`, default 4: command FIFO entries; power of two, at least 2.
- `TAG_W`, default 4: width of the opaque tag carried with each command.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: command offered.
- `in_ready` output 1: command accepted this edge when `in_valid & in_ready`.
- `in_src1` input 32: operand A.
- `in_src2` input 32: operand B.
- `in_ctrl` input 4: ALU_control code.
- `in_tag` input TAG_W: passed through unchanged.
- `out_valid` output 1: result register holds a result.
- `out_ready` input 1: consumer takes the result when `out_valid & out_ready`.
- `out_result` output 32: ALU result.
- `out_zero` output 1: ALU zero flag.
- `out_cout` output 1: ALU carry out.
- `out_overflow` output 1: ALU overflow flag.
- `out_tag` output TAG_W: tag of the result.
- `err_illegal` output 1: one-cycle pulse when an illegal code is accepted.
- `flags_clr` input 1: clears sticky flags.
- `sticky_ovf` output 1: sticky overflow status.
- `sticky_cout` output 1: sticky carry status.

## Operation
- Legal codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0111 SLT, 1100 NOR, 1101 NAND.
  - Any other code is illegal.
- `in_ready` = FIFO not full. It is combinational from the occupancy count; there is no bypass when full.
- Legal accepted command: written at the FIFO tail.
- Illegal accepted command: the handshake completes, nothing is enqueued, and `err_illegal` goes high for exactly the following cycle.
- Issue condition: FIFO non-empty AND (`out_valid`=0 OR `out_ready`=1).
  - On issue, the head command's operands and code drive the internal `alu` combinationally.
  - `out_result`, flags and tag are registered from it, `out_valid` is set, and the head is popped.
- Drain without issue: `out_valid` clears when `out_ready`=1 and no issue happens that cycle.
- Push and pop in the same cycle are allowed whenever not full; occupancy is unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is a log2(DEPTH)+1-bit counter.
- Results retire in acceptance order.
- Output register contents are held stable while `out_valid & ~out_ready`.
- `rst_n` on the internal `alu` is tied to `rst_n`.

## Timing
- Latency: a command accepted at edge N into an empty queue, with the output register free, appears with `out_valid`=1 after edge N+1.
- Throughput: one result per cycle with `out_ready` held high.
- Capacity: DEPTH+1 commands are in flight (FIFO plus output register).
- Reset values (asynchronous, immediate):
  - FIFO empty, `in_ready`=1.
  - `out_valid`=0.
  - `out_result`=0, `out_zero`=0, `out_cout`=0, `out_overflow`=0, `out_tag`=0.
  - `err_illegal`=0, `sticky_ovf`=0, `sticky_cout`=0.
- Reset mid-operation: queued and registered commands are discarded; no partial result is emitted.

## Configuration
- `ALU_STICKY_FLAGS_EN` defined:
  - `sticky_ovf` and `sticky_cout` set on any issue whose ALU overflow or cout is 1.
  - They clear on `flags_clr`.
  - Set and clear in the same cycle: set wins.
- Undefined:
  - The ports remain.
  - `sticky_ovf` and `sticky_cout` are tied to 0.
  - `flags_clr` is ignored.
  - No sticky registers are synthesized.

## Structure
- Package `alu_pkg` holds:
  - Localparams for the seven legal ALU_control codes.
  - An `is_legal_ctrl` function.
  - The command record type (src1, src2, ctrl, tag).
- Sub-module `alu_cmd_fifo`: parameterised synchronous FIFO with push/pop, full/empty and count.
- Top-level contents: the FIFO, one `alu` instance, the output register, and the sticky logic.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow=1, cout=0, zero=0; `out_valid` high one cycle after accept.
- SUB 5 − 5 → result 0, zero=1, cout=1. SLT 0xFFFFFFFF vs 0x00000001 → result 1.
- Backpressure with `out_ready`=0 and DEPTH=4, tags 0..5 offered:
  - Tags 0..4 accepted, then `in_ready`=0.
  - Raise `out_ready`: tags 0..4 retire in order on consecutive cycles.
- Illegal code 0011 accepted:
  - `err_illegal` pulses once; no result emitted.
  - An OR command behind it retires normally.
- Reset mid-stream: 3 commands queued, `rst_n` pulsed low → `out_valid`=0, `in_ready`=1, no stale results after release.
- With `ALU_STICKY_FLAGS_EN`:
  - An overflowing ADD sets `sticky_ovf` and it stays set across later clean ops.
  - `flags_clr` coincident with another overflowing issue leaves it set.
  - `flags_clr` alone clears it.
